banked_register_file: RTL and testbench
=======================================

# banked_register_file

Multi-bank warp register file serving operand-collector read requests and execution-unit writebacks. Each bank supports one access per cycle (read or write). Read ports compete per bank with round-robin arbitration, and writes always win their bank. Read data returns a fixed one cycle after the request handshake, on the same port index. It sits directly downstream of the operand collector's read-request/response interface and upstream of nothing but the collector itself.

## Interface
- NumWarps, 8, warps per compute unit
- WarpWidth, 32, threads per warp
- RegWidth, 32, bits per thread register
- RegIdxWidth, 6, architectural register index width (registers per warp = 2^RegIdxWidth)
- NumReadPorts, 2, read ports (one per operand slot)
- NumBanks, 4, banks; power of two, 1 ≤ NumBanks ≤ 2^RegIdxWidth
- Derived (do not override): WidWidth = NumWarps>1 ? $clog2(NumWarps) : 1; BankWidth = NumBanks>1 ? $clog2(NumBanks) : 1; warp_data_t = logic [RegWidth*WarpWidth-1:0]

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, synchronous, active-high
- read_req_valid_i  in  [NumReadPorts]  read request per port
- read_req_wid_i  in  [NumReadPorts][WidWidth]  warp id
- read_req_reg_idx_i  in  [NumReadPorts][RegIdxWidth]  register index
- read_req_ready_o  out  [NumReadPorts]  request granted this cycle
- read_rsp_valid_o  out  [NumReadPorts]  response valid
- read_rsp_data_o  out  [NumReadPorts] warp_data_t  response data
- wb_valid_i  in  1  write request; always accepted, no ready
- wb_wid_i  in  WidWidth  warp id
- wb_reg_idx_i  in  RegIdxWidth  destination register
- wb_act_mask_i  in  WarpWidth  per-thread write enable
- wb_data_i  in  warp_data_t  write data

## Operation
- Bank of (wid, idx) = (idx + wid) mod NumBanks, using the low BankWidth bits of the sum. Row = {wid, idx[RegIdxWidth-1:BankWidth]}. Rows per bank = NumWarps·2^RegIdxWidth/NumBanks. The warp skew spreads the same register index across warps.
- Per bank, each cycle:
  - If wb_valid_i targets the bank, the write occurs. Only threads with wb_act_mask_i[t]=1 update slice t. No read to that bank is granted.
  - Otherwise, among ports with valid requests mapping to the bank, one winner is chosen round-robin and read_req_ready_o[winner]=1.
  - Round-robin pointer: after a grant it moves to winner+1 (mod NumReadPorts). It holds if there is no grant. Initial pointer is 0.
- Two ports reading the same register are serialized; there is no duplicate-read merging.
- A port with no valid request, or whose bank is lost to another port or to a write, has ready=0. read_req_ready_o does not depend on the request's own valid except through arbitration.
- A request may be held or withdrawn while ready=0; the block keeps no request state.
- Storage contents are not reset. A read of a never-written register returns X in simulation.

## Timing
- Read latency is exactly 1. A handshake on port p in cycle t gives read_rsp_valid_o[p]=1 in cycle t+1 with the data registered. It is a single-cycle pulse; there is no rsp back-pressure.
- Back-to-back grants on one port produce responses in consecutive cycles.
- A write in cycle t is visible to a read granted in cycle t+1 or later. A same-cycle same-bank read cannot occur (write priority), so no bypass is required.
- Reset values: read_rsp_valid_o=0, read_rsp_data_o=0, all arbiter pointers=0. read_req_ready_o is combinational: 0 when there is no valid request, otherwise per arbitration.
- rst_i asserted mid-operation: any response due next cycle is dropped (rsp_valid=0 during and one cycle after reset) and pointers return to 0. Storage is unchanged.
- A write with an all-zero act_mask still occupies the bank for that cycle.

## Structure
- Bank-mapping function (bank index, row index) and warp_data_t go in bgpu_pkg, so the collector and testbench can predict conflicts.
- Sub-module regfile_bank: 1R1W-per-cycle storage (exclusive), per-thread write mask, registered read data. It is instantiated NumBanks times.
- Per-bank arbitration uses the common_cells round-robin arbiter or an inline pointer. The top level routes the winning row to the bank and steers bank data back to the winning port's response register.

## Test plan
- Reset, then write wid 0 / r5 with data 0xA5A5A5A5 in all threads; read wid 0 / r5 on port 0 the next cycle -> ready=1, rsp_valid_o[0]=1 one cycle later with all threads 0xA5A5A5A5.
- Ports 0 and 1 both read wid 0 / r1 and r5 (same bank when NumBanks=4), held valid -> port 0 granted cycle t, port 1 at t+1; responses at t+1 and t+2. The next conflict is granted to port 1 first.
- Port 0 reads wid 0 / r0 and port 1 reads wid 1 / r0 in the same cycle -> different banks via skew, both ready=1, both responses next cycle.
- Write to wid 2 / r3 with act_mask 0x0000_FFFF concurrent with a read to the same bank -> read ready=0. The next-cycle read returns new data in threads 0–15 and old data in threads 16–31.
- Stream 8 back-to-back reads on port 0 to distinct banks -> ready=1 every cycle, 8 consecutive rsp_valid pulses in order.
- Assert rst_i the cycle after a granted read -> rsp_valid stays 0. Post-reset arbitration starts at port 0, and stored data survives reset.

Source files
------------

// File: rtl/bgpu_pkg.sv
// Shared definitions for the warp register file and its neighbours.
// Holds the default configuration, the warp data type and the bank/row
// mapping helpers, so that the operand collector and the testbench can
// predict bank conflicts with exactly the same rule the register file uses.
package bgpu_pkg;

  localparam int unsigned NUM_WARPS      = 32'd8;
  localparam int unsigned WARP_WIDTH     = 32'd32;
  localparam int unsigned REG_WIDTH      = 32'd32;
  localparam int unsigned REG_IDX_WIDTH  = 32'd6;
  localparam int unsigned NUM_READ_PORTS = 32'd2;
  localparam int unsigned NUM_BANKS      = 32'd4;

  typedef logic [REG_WIDTH*WARP_WIDTH-1:0] warp_data_t;

  // Bank holding (wid, idx). The warp id skews the mapping so the same
  // register index of different warps lands in different banks.
  function automatic int unsigned bank_of(input int unsigned wid,
                                          input int unsigned idx,
                                          input int unsigned num_banks);
    return (wid + idx) % num_banks;
  endfunction

  // Row inside the bank: {wid, idx without its low bank bits}.
  function automatic int unsigned row_of(input int unsigned wid,
                                         input int unsigned idx,
                                         input int unsigned num_banks,
                                         input int unsigned reg_idx_width);
    return wid * ((32'd1 << reg_idx_width) / num_banks) + idx / num_banks;
  endfunction

endpackage

// File: rtl/regfile_bank.sv
// One register-file bank: NumRows rows of one warp register each.
// Exactly one access per cycle (the top level guarantees read and write
// are never enabled together). Writes honour a per-thread mask; read data
// is registered and holds until the next read.
// Ports:
//   i_clk       clock
//   i_wr_en     write this cycle
//   i_wr_row    row to write
//   i_wr_mask   per-thread write enable
//   i_wr_data   write data
//   i_rd_en     read this cycle
//   i_rd_row    row to read
//   o_rd_data   data of the last read, valid the cycle after i_rd_en
module regfile_bank #(
  parameter int unsigned NumRows   = 32'd128,
  parameter int unsigned RowWidth  = 32'd7,
  parameter int unsigned WarpWidth = 32'd32,
  parameter int unsigned RegWidth  = 32'd32
) (
  input  logic                          i_clk,
  input  logic                          i_wr_en,
  input  logic [RowWidth-1:0]           i_wr_row,
  input  logic [WarpWidth-1:0]          i_wr_mask,
  input  logic [RegWidth*WarpWidth-1:0] i_wr_data,
  input  logic                          i_rd_en,
  input  logic [RowWidth-1:0]           i_rd_row,
  output logic [RegWidth*WarpWidth-1:0] o_rd_data
);

  logic [RegWidth*WarpWidth-1:0] r_mem [NumRows];
  logic [RegWidth*WarpWidth-1:0] r_rd_data;

  // Storage write with per-thread mask and registered read; storage is
  // intentionally not reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      for (int t = 0; t < int'(WarpWidth); t++) begin
        if (i_wr_mask[t]) begin
          r_mem[i_wr_row][t*RegWidth +: RegWidth] <= i_wr_data[t*RegWidth +: RegWidth];
        end
      end
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_row];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/banked_register_file.sv
// Multi-bank warp register file. Each bank takes one access per cycle:
// a writeback always wins its bank, otherwise the read ports targeting
// the bank are arbitrated round-robin. Read data returns exactly one cycle
// after the handshake on the same port index.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   read_req_valid_i/wid_i/reg_idx_i  per-port read request
//   read_req_ready_o                  per-port grant (combinational)
//   read_rsp_valid_o/data_o           per-port response, one-cycle pulse
//   wb_valid_i/wid_i/reg_idx_i        writeback request, always accepted
//   wb_act_mask_i, wb_data_i          per-thread enable and write data
module banked_register_file
  import bgpu_pkg::*;
#(
  parameter int unsigned NumWarps     = NUM_WARPS,
  parameter int unsigned WarpWidth    = WARP_WIDTH,
  parameter int unsigned RegWidth     = REG_WIDTH,
  parameter int unsigned RegIdxWidth  = REG_IDX_WIDTH,
  parameter int unsigned NumReadPorts = NUM_READ_PORTS,
  parameter int unsigned NumBanks     = NUM_BANKS
) (
  input  logic                                            clk_i,
  input  logic                                            rst_i,
  input  logic [NumReadPorts-1:0]                         read_req_valid_i,
  input  logic [NumReadPorts-1:0][((NumWarps>1)?$clog2(NumWarps):1)-1:0] read_req_wid_i,
  input  logic [NumReadPorts-1:0][RegIdxWidth-1:0]        read_req_reg_idx_i,
  output logic [NumReadPorts-1:0]                         read_req_ready_o,
  output logic [NumReadPorts-1:0]                         read_rsp_valid_o,
  output logic [NumReadPorts-1:0][RegWidth*WarpWidth-1:0] read_rsp_data_o,
  input  logic                                            wb_valid_i,
  input  logic [((NumWarps>1)?$clog2(NumWarps):1)-1:0]    wb_wid_i,
  input  logic [RegIdxWidth-1:0]                          wb_reg_idx_i,
  input  logic [WarpWidth-1:0]                            wb_act_mask_i,
  input  logic [RegWidth*WarpWidth-1:0]                   wb_data_i
);

  localparam int unsigned DataWidth = RegWidth * WarpWidth;
  localparam int unsigned BankWidth = (NumBanks > 32'd1) ? $clog2(NumBanks) : 32'd1;
  localparam int unsigned PortWidth = (NumReadPorts > 32'd1) ? $clog2(NumReadPorts) : 32'd1;
  localparam int unsigned NumRows   = NumWarps * (32'd1 << RegIdxWidth) / NumBanks;
  localparam int unsigned RowWidth  = (NumRows > 32'd1) ? $clog2(NumRows) : 32'd1;

  logic [NumReadPorts-1:0][BankWidth-1:0] w_req_bank;
  logic [NumReadPorts-1:0][RowWidth-1:0]  w_req_row;
  logic [BankWidth-1:0]                   w_wb_bank;
  logic [RowWidth-1:0]                    w_wb_row;

  logic [NumBanks-1:0][PortWidth-1:0]     r_rr_ptr;
  logic [NumBanks-1:0][PortWidth-1:0]     w_rr_ptr_nxt;
  logic [NumBanks-1:0][NumReadPorts-1:0]  w_grant;
  logic [NumBanks-1:0]                    w_rd_en;
  logic [NumBanks-1:0]                    w_wr_en;
  logic [NumBanks-1:0][RowWidth-1:0]      w_rd_row;
  logic [NumBanks-1:0][DataWidth-1:0]     w_bank_rd_data;

  logic [NumReadPorts-1:0]                r_rsp_valid;
  logic [NumReadPorts-1:0][BankWidth-1:0] r_rsp_bank;

  // Bank/row mapping of every read request and of the writeback.
  always_comb begin
    for (int p = 0; p < int'(NumReadPorts); p++) begin
      w_req_bank[p] = BankWidth'(bank_of(32'(read_req_wid_i[p]), 32'(read_req_reg_idx_i[p]), NumBanks));
      w_req_row[p]  = RowWidth'(row_of(32'(read_req_wid_i[p]), 32'(read_req_reg_idx_i[p]), NumBanks, RegIdxWidth));
    end
    w_wb_bank = BankWidth'(bank_of(32'(wb_wid_i), 32'(wb_reg_idx_i), NumBanks));
    w_wb_row  = RowWidth'(row_of(32'(wb_wid_i), 32'(wb_reg_idx_i), NumBanks, RegIdxWidth));
  end

  // Per-bank arbitration. Pass 0 scans ports at or above the pointer,
  // pass 1 wraps around to the ports below it, which yields round-robin
  // order without a variable rotate. No grants are issued while in reset.
  always_comb begin
    w_grant      = '0;
    w_rd_en      = '0;
    w_wr_en      = '0;
    w_rd_row     = '0;
    w_rr_ptr_nxt = r_rr_ptr;
    for (int b = 0; b < int'(NumBanks); b++) begin
      if (wb_valid_i && (w_wb_bank == BankWidth'(b))) begin
        w_wr_en[b] = 1'b1;
      end else if (!rst_i) begin
        for (int pass = 0; pass < 2; pass++) begin
          for (int p = 0; p < int'(NumReadPorts); p++) begin
            if (!w_rd_en[b] && read_req_valid_i[p] && (w_req_bank[p] == BankWidth'(b)) &&
                ((pass == 1) || (PortWidth'(p) >= r_rr_ptr[b]))) begin
              w_grant[b][p] = 1'b1;
              w_rd_en[b]    = 1'b1;
              w_rd_row[b]   = w_req_row[p];
              if (p == int'(NumReadPorts) - 1) begin
                w_rr_ptr_nxt[b] = '0;
              end else begin
                w_rr_ptr_nxt[b] = PortWidth'(p + 1);
              end
            end else begin
              w_grant[b][p] = w_grant[b][p];
            end
          end
        end
      end else begin
        w_wr_en[b] = 1'b0;
      end
    end
  end

  // A port is ready when any bank granted it.
  always_comb begin
    read_req_ready_o = '0;
    for (int b = 0; b < int'(NumBanks); b++) begin
      read_req_ready_o = read_req_ready_o | w_grant[b];
    end
  end

  // Round-robin pointers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr <= '0;
    end else begin
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // Response tracking: remember which bank serves each granted port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rsp_valid <= '0;
      r_rsp_bank  <= '0;
    end else begin
      r_rsp_valid <= read_req_ready_o;
      for (int p = 0; p < int'(NumReadPorts); p++) begin
        if (read_req_ready_o[p]) begin
          r_rsp_bank[p] <= w_req_bank[p];
        end
      end
    end
  end

  // A response already registered when reset arrives is dropped
  // immediately, so valid stays low for the whole reset cycle too.
  assign read_rsp_valid_o = r_rsp_valid & ~{NumReadPorts{rst_i}};

  // Steer the registered bank data to the port that owns it.
  always_comb begin
    for (int p = 0; p < int'(NumReadPorts); p++) begin
      if (read_rsp_valid_o[p]) begin
        read_rsp_data_o[p] = w_bank_rd_data[r_rsp_bank[p]];
      end else begin
        read_rsp_data_o[p] = '0;
      end
    end
  end

  for (genvar b = 0; b < int'(NumBanks); b++) begin : g_bank
    regfile_bank #(
      .NumRows  (NumRows),
      .RowWidth (RowWidth),
      .WarpWidth(WarpWidth),
      .RegWidth (RegWidth)
    ) u_bank (
      .i_clk    (clk_i),
      .i_wr_en  (w_wr_en[b]),
      .i_wr_row (w_wb_row),
      .i_wr_mask(wb_act_mask_i),
      .i_wr_data(wb_data_i),
      .i_rd_en  (w_rd_en[b]),
      .i_rd_row (w_rd_row[b]),
      .o_rd_data(w_bank_rd_data[b])
    );
  end

endmodule

// File: tb/tb_banked_register_file.sv
// Self-checking bench for banked_register_file. A driver applies one
// cycle of stimulus at a time, predicts grants and read data from a
// plain behavioural model (register array + per-bank pointers) and
// pushes expected responses into per-port queues; a separate monitor
// pops and compares whenever the DUT presents a response.
module tb_banked_register_file;
  import bgpu_pkg::*;

  localparam int NW = 8;
  localparam int NR = 64;
  localparam int NP = 2;
  localparam int NB = 4;
  localparam int TH = 32;

  typedef struct {
    int         due;
    warp_data_t data;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_i;
  logic [1:0]           read_req_valid_i;
  logic [1:0][2:0]      read_req_wid_i;
  logic [1:0][5:0]      read_req_reg_idx_i;
  logic [1:0]           read_req_ready_o;
  logic [1:0]           read_rsp_valid_o;
  logic [1:0][1023:0]   read_rsp_data_o;
  logic                 wb_valid_i;
  logic [2:0]           wb_wid_i;
  logic [5:0]           wb_reg_idx_i;
  logic [31:0]          wb_act_mask_i;
  logic [1023:0]        wb_data_i;

  banked_register_file dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .read_req_valid_i  (read_req_valid_i),
    .read_req_wid_i    (read_req_wid_i),
    .read_req_reg_idx_i(read_req_reg_idx_i),
    .read_req_ready_o  (read_req_ready_o),
    .read_rsp_valid_o  (read_rsp_valid_o),
    .read_rsp_data_o   (read_rsp_data_o),
    .wb_valid_i        (wb_valid_i),
    .wb_wid_i          (wb_wid_i),
    .wb_reg_idx_i      (wb_reg_idx_i),
    .wb_act_mask_i     (wb_act_mask_i),
    .wb_data_i         (wb_data_i)
  );

  always #5 clk = ~clk;

  // staged stimulus for the next cycle
  logic       s_rst;
  logic [1:0] s_rv;
  int         s_wid [NP];
  int         s_idx [NP];
  logic       s_wbv;
  int         s_wbwid;
  int         s_wbidx;
  logic [31:0] s_mask;
  warp_data_t s_wbdata;

  // reference model
  warp_data_t m_mem [NW][NR];
  int         m_ptr [NB];
  exp_t       exp_q [NP][$];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  function automatic warp_data_t rnd_data();
    warp_data_t d;
    for (int i = 0; i < TH; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic int first_bad_thread(input warp_data_t a, input warp_data_t b);
    for (int t = 0; t < TH; t++) begin
      if (a[t*32 +: 32] !== b[t*32 +: 32]) return t;
    end
    return 0;
  endfunction

  task automatic idle();
    s_rst = 1'b0; s_rv = 2'b00; s_wbv = 1'b0; s_mask = 32'h0;
    s_wbdata = '0; s_wbwid = 0; s_wbidx = 0;
    for (int p = 0; p < NP; p++) begin s_wid[p] = 0; s_idx[p] = 0; end
  endtask

  // One cycle: apply stimulus, predict and check grants, update model.
  task automatic tick(input int fixed_rdy);
    logic [1:0] exp_rdy;
    int wb_bank;
    bit found;
    int p;
    @(negedge clk);
    rst_i            = s_rst;
    read_req_valid_i = s_rv;
    for (int i = 0; i < NP; i++) begin
      read_req_wid_i[i]     = 3'(s_wid[i]);
      read_req_reg_idx_i[i] = 6'(s_idx[i]);
    end
    wb_valid_i    = s_wbv;
    wb_wid_i      = 3'(s_wbwid);
    wb_reg_idx_i  = 6'(s_wbidx);
    wb_act_mask_i = s_mask;
    wb_data_i     = s_wbdata;
    cyc++;
    #1;
    exp_rdy = 2'b00;
    if (s_rst) begin
      for (int i = 0; i < NP; i++) begin
        while (exp_q[i].size() > 0 && exp_q[i][0].due <= cyc) void'(exp_q[i].pop_front());
      end
      for (int b = 0; b < NB; b++) m_ptr[b] = 0;
    end else begin
      wb_bank = s_wbv ? (s_wbwid + s_wbidx) % NB : -1;
      for (int b = 0; b < NB; b++) begin
        found = 1'b0;
        if (b != wb_bank) begin
          for (int k = 0; k < NP; k++) begin
            p = (m_ptr[b] + k) % NP;
            if (!found && s_rv[p] && ((s_wid[p] + s_idx[p]) % NB == b)) begin
              found = 1'b1;
              exp_rdy[p] = 1'b1;
              exp_q[p].push_back('{due: cyc + 1, data: m_mem[s_wid[p]][s_idx[p]]});
              m_ptr[b] = (p + 1) % NP;
            end
          end
        end
      end
    end
    n_tests++;
    if (read_req_ready_o !== exp_rdy) begin
      n_fail++;
      $display("FAIL ready_model cyc %0d got %b need %b", cyc, read_req_ready_o, exp_rdy);
    end
    if (fixed_rdy >= 0) begin
      n_tests++;
      if (read_req_ready_o !== 2'(fixed_rdy)) begin
        n_fail++;
        $display("FAIL ready_directed cyc %0d got %b need %b", cyc, read_req_ready_o, 2'(fixed_rdy));
      end
    end
    if (s_wbv) begin
      for (int t = 0; t < TH; t++) begin
        if (s_mask[t]) m_mem[s_wbwid][s_wbidx][t*32 +: 32] = s_wbdata[t*32 +: 32];
      end
    end
  endtask

  // Monitor: compare every presented response against the scoreboard.
  exp_t mon_e;
  int   mon_t;
  always @(negedge clk) begin
    #3;
    for (int p = 0; p < NP; p++) begin
      if (read_rsp_valid_o[p] === 1'b1) begin
        n_tests++;
        if (exp_q[p].size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected port %0d cyc %0d got valid 1 need 0", p, cyc);
        end else begin
          mon_e = exp_q[p].pop_front();
          mon_t = first_bad_thread(read_rsp_data_o[p], mon_e.data);
          if (mon_e.due != cyc || read_rsp_data_o[p] !== mon_e.data) begin
            n_fail++;
            $display("FAIL rsp_data port %0d cyc %0d (due %0d) thread %0d got %h need %h",
                     p, cyc, mon_e.due, mon_t, read_rsp_data_o[p][mon_t*32 +: 32],
                     mon_e.data[mon_t*32 +: 32]);
          end
        end
      end else if (exp_q[p].size() > 0 && exp_q[p][0].due <= cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_missing port %0d cyc %0d got valid %b need 1", p, cyc, read_rsp_valid_o[p]);
        void'(exp_q[p].pop_front());
      end
    end
  end

  initial begin
    rst_i = 1'b1; read_req_valid_i = '0; read_req_wid_i = '0; read_req_reg_idx_i = '0;
    wb_valid_i = 1'b0; wb_wid_i = '0; wb_reg_idx_i = '0; wb_act_mask_i = '0; wb_data_i = '0;
    for (int b = 0; b < NB; b++) m_ptr[b] = 0;
    idle();

    // reset
    s_rst = 1'b1; tick(-1); tick(-1);
    idle(); tick(0);
    n_tests++;
    if (read_rsp_valid_o !== 2'b00 || read_rsp_data_o !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got valid %b need 00 (data nonzero or X: %b)",
               read_rsp_valid_o, read_rsp_data_o !== '0);
    end

    // preload every register so later random reads are defined
    for (int w = 0; w < NW; w++) begin
      for (int i = 0; i < NR; i++) begin
        s_wbv = 1'b1; s_wbwid = w; s_wbidx = i; s_mask = 32'hFFFF_FFFF; s_wbdata = rnd_data();
        tick(0);
      end
    end
    idle();

    // write wid0/r5 then read it the next cycle
    s_wbv = 1'b1; s_wbwid = 0; s_wbidx = 5; s_mask = 32'hFFFF_FFFF; s_wbdata = {32{32'hA5A5_A5A5}};
    tick(0);
    idle(); s_rv = 2'b01; s_wid[0] = 0; s_idx[0] = 5; tick(1);
    idle(); tick(0);

    // skewed banks: wid0/r0 and wid1/r0 both granted
    s_rv = 2'b11; s_wid[0] = 0; s_idx[0] = 0; s_wid[1] = 1; s_idx[1] = 0; tick(3);
    idle(); tick(0);

    // grant then reset: response dropped, pointers cleared
    s_rv = 2'b01; s_wid[0] = 0; s_idx[0] = 5; tick(1);
    idle(); s_rst = 1'b1; tick(0);
    idle(); tick(0);

    // conflict wid0/r1 vs wid0/r5 after reset: port 0 first, then port 1
    s_rv = 2'b11; s_wid[0] = 0; s_idx[0] = 1; s_wid[1] = 0; s_idx[1] = 5;
    tick(1); tick(2); tick(-1);
    idle(); tick(0);

    // masked write to wid2/r3 blocks same-bank reads that cycle
    s_wbv = 1'b1; s_wbwid = 2; s_wbidx = 3; s_mask = 32'h0000_FFFF; s_wbdata = rnd_data();
    s_rv = 2'b11; s_wid[0] = 2; s_idx[0] = 3; s_wid[1] = 1; s_idx[1] = 0;
    tick(0);
    idle(); s_rv = 2'b01; s_wid[0] = 2; s_idx[0] = 3; tick(1);

    // all-zero mask still occupies the bank
    idle(); s_wbv = 1'b1; s_wbwid = 0; s_wbidx = 1; s_mask = 32'h0; s_wbdata = rnd_data();
    s_rv = 2'b01; s_wid[0] = 0; s_idx[0] = 5; tick(0);
    idle(); s_rv = 2'b01; s_wid[0] = 0; s_idx[0] = 1; tick(1);

    // 8 back-to-back reads on port 0 to rotating banks
    for (int i = 0; i < 8; i++) begin
      idle(); s_rv = 2'b01; s_wid[0] = 0; s_idx[0] = i; tick(1);
    end
    idle(); tick(0); tick(0);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      s_rst = ($urandom_range(99) == 0);
      s_rv  = 2'($urandom_range(3));
      for (int p = 0; p < NP; p++) begin
        s_wid[p] = $urandom_range(NW - 1);
        s_idx[p] = ($urandom_range(1) == 0) ? $urandom_range(7) : $urandom_range(NR - 1);
      end
      s_wbv    = ($urandom_range(9) < 3);
      s_wbwid  = $urandom_range(NW - 1);
      s_wbidx  = $urandom_range(NR - 1);
      s_mask   = ($urandom_range(1) == 0) ? 32'hFFFF_FFFF : $urandom;
      s_wbdata = rnd_data();
      tick(-1);
    end

    idle(); tick(0); tick(0); tick(0);
    for (int p = 0; p < NP; p++) begin
      n_tests++;
      if (exp_q[p].size() != 0) begin
        n_fail++;
        $display("FAIL drain port %0d got %0d pending need 0", p, exp_q[p].size());
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
